core_memory: RTL and testbench
==============================

// Module: core_memory
// PURPOSE
// - Memory subsystem directly downstream of the core. It serves the core's instruction fetch
//   port (pc_to_mem -> ld_data_for_inst) and its data load/store port (mem_addr/st_data/we -> ld_data).
// - Both ports are backed by one shared on-chip word array.
// - A memory-mapped TX word drains stored bytes through a small FIFO to a byte-stream
//   (valid/ready) consumer such as a UART.
// PARAMETERS
// - LOAD_LATENCY  1        cycles from address to read data on both ports; must be >= 1 and equal the core's value
// - MEM_WORDS     4096     number of 64-bit words in the array
// - INIT_FILE     ""       $readmemh image loaded at elaboration; empty string = array left uninitialised
// - MMIO_TX_ADDR  'hFFF8   byte address of the TX/status word; must be 8-byte aligned
// - TXQ_DEPTH     16       TX FIFO entries; must be a power of 2
// PORTS
// - clk               in   1          single clock, rising edge
// - rstn              in   1          reset, asynchronous, active-low
// - pc_to_mem         in   ADDR_W     instruction fetch byte address
// - ld_data_for_inst  out  DATA_W     fetched word
// - mem_addr          in   ADDR_W     data byte address
// - st_data           in   DATA_W     store data, already lane-aligned by the core
// - we                in   DATA_W/8   byte write enables; we[i] covers st_data[8i+7:8i]
// - ld_data           out  DATA_W     load data word
// - tx_data           out  8          TX FIFO head byte
// - tx_valid          out  1          TX FIFO non-empty
// - tx_ready          in   1          consumer accepts tx_data this cycle
// - tx_overflow       out  1          sticky: a TX push was dropped because the FIFO was full
// BEHAVIOUR
// - Word index = addr[ADDR_W-1:3]; addr[2:0] is ignored. Byte offset k sits at bits [63-8k -: 8],
//   so offset 0 is we[7] and offset 7 is we[0].
// - Reads: data for an address presented in cycle t appears at t+LOAD_LATENCY on both ports.
//   The first stage is the registered array read; the remaining LOAD_LATENCY-1 stages are pipeline registers.
// - Writes commit at the clock edge of the cycle in which we != 0; only enabled lanes change.
// - Read-during-write to the same word (data port, or instruction port vs data port): read returns OLD data.
// - Index >= MEM_WORDS: writes are dropped, reads return 0. No wrap-around.
// - MMIO_TX_ADDR word is never written to the array.
//   - A store there with we[0]=1 pushes st_data[7:0] into the TX FIFO.
//   - A load there returns {62'b0, txq_empty, txq_full}, sampled in the request cycle, with normal latency.
//   - Instruction fetch from this address returns 0.
// - TX FIFO:
//   - tx_valid = !empty; tx_data = head byte; pop on tx_valid && tx_ready.
//   - Push while full without a same-cycle pop: byte dropped and tx_overflow set until reset.
//   - Push and pop in the same cycle while full: both happen and occupancy is unchanged.
//   - Push while empty: tx_valid rises the next cycle (no fall-through).
//   - Pointers have log2(TXQ_DEPTH)+1 bits; full/empty are decided by the MSB compare.
// - Reset, at any time including mid-operation:
//   - ld_data, ld_data_for_inst and every pipeline stage -> 0.
//   - FIFO pointers -> 0, so tx_valid=0, tx_data=0, tx_overflow=0.
//   - Array contents are not cleared; a write in the reset cycle is dropped.
//   - Outputs are 0 for the first LOAD_LATENCY cycles after rstn rises.
// STRUCTURE
// - common_params.h: add `MMIO_TX_ADDR default and a mem_lane_t typedef (DATA_W/8 enable vector).
//   DATA_W and ADDR_W already live there.
// - Sub-module tx_fifo (params WIDTH=8, DEPTH), with ports push/push_data/pop/head/full/empty and async active-low reset.
// - Top level holds the array (inferred true dual-port RAM), the address decode, the latency pipelines and the overflow flag.
// TESTING
// - Store st_data=64'h1122334455667788, we=8'hFF @0x40; load 0x40 -> ld_data=64'h1122334455667788
//   exactly LOAD_LATENCY cycles later. Repeat with LOAD_LATENCY=1 and 3.
// - Partial store we=8'h80, st_data[63:56]=8'hAA @0x40, then load -> 64'hAA22334455667788
//   (only the offset-0 lane changed).
// - Fetch pc_to_mem=0x40 in the same cycle as a store to 0x48 ->
//   ld_data_for_inst returns the old word at 0x40.
// - Same cycle: load 0x40 and store 0x40 -> ld_data returns the old word; a load of 0x40 next cycle returns the new word.
// - Push 17 bytes (0x00..0x10) to MMIO_TX_ADDR, we=8'h01, tx_ready=0 -> 16 accepted and tx_overflow=1.
//   With tx_ready=1 the drain is 0x00..0x0F in order, then tx_valid=0.
// - Assert rstn=0 mid-drain with FIFO holding 5 and a load in flight -> tx_valid=0 and ld_data=0
//   immediately (async). Load 0x40 after release -> array contents preserved.

Source files
------------

// File: rtl/core_memory_pkg.sv
// Shared widths, defaults and address helpers for the core memory subsystem.
package core_memory_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 16;
    localparam int LANES  = DATA_W / 8;
    localparam int WIDX_W = ADDR_W - 3;

    localparam logic [ADDR_W-1:0] MMIO_TX_ADDR_DEFAULT = 16'hFFF8;

    typedef logic [LANES-1:0]  mem_lane_t;
    typedef logic [WIDX_W-1:0] word_idx_t;

    // Byte address to 64-bit word index; the low three bits select a byte and are ignored.
    function automatic word_idx_t word_index(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:3];
    endfunction

endpackage

// File: rtl/core_memory_tx_fifo.sv
// Small synchronous FIFO feeding the TX byte stream. Registered head (no fall-through);
// pointers carry one extra wrap bit so full/empty come from the MSB compare.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] store [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a push while full is still taken when paired with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero while empty so the stream data is clean after reset.
    assign head = empty ? '0 : store[rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/core_memory.sv
// Shared word array behind the core's fetch and load/store ports, plus the memory-mapped
// TX word that feeds a byte-stream FIFO.
module core_memory
    import core_memory_pkg::*;
#(
    parameter int                LOAD_LATENCY = 1,
    parameter int                MEM_WORDS    = 4096,
    parameter string             INIT_FILE    = "",
    parameter logic [ADDR_W-1:0] MMIO_TX_ADDR = MMIO_TX_ADDR_DEFAULT,
    parameter int                TXQ_DEPTH    = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_to_mem,
    output logic [DATA_W-1:0] ld_data_for_inst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] st_data,
    input  mem_lane_t         we,
    output logic [DATA_W-1:0] ld_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_overflow
);

    localparam int MIDX_W = $clog2(MEM_WORDS);
    localparam word_idx_t          MMIO_IDX    = MMIO_TX_ADDR[ADDR_W-1:3];
    localparam logic [WIDX_W:0]    MEM_WORDS_L = MEM_WORDS[WIDX_W:0];

    word_idx_t         d_idx;
    word_idx_t         i_idx;
    logic              d_in_range;
    logic              i_in_range;
    logic              d_is_mmio;
    logic              i_is_mmio;
    logic [MIDX_W-1:0] d_ram_addr;
    logic [MIDX_W-1:0] i_ram_addr;
    logic              wr_ok;

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [DATA_W-1:0] d_rd_raw;
    logic [DATA_W-1:0] i_rd_raw;

    logic              d_mem_q;
    logic              d_mmio_q;
    logic [1:0]        d_stat_q;
    logic              i_mem_q;
    logic [DATA_W-1:0] d_stage1;
    logic [DATA_W-1:0] i_stage1;

    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;

    logic              unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr[2:0], pc_to_mem[2:0]};

    assign d_idx      = word_index(mem_addr);
    assign i_idx      = word_index(pc_to_mem);
    assign d_in_range = ({1'b0, d_idx} < MEM_WORDS_L);
    assign i_in_range = ({1'b0, i_idx} < MEM_WORDS_L);
    assign d_is_mmio  = (d_idx == MMIO_IDX);
    assign i_is_mmio  = (i_idx == MMIO_IDX);
    assign d_ram_addr = d_idx[MIDX_W-1:0];
    assign i_ram_addr = i_idx[MIDX_W-1:0];

    // Out-of-range and MMIO stores never reach the array; gating with rstn drops a store in the reset cycle.
    assign wr_ok   = rstn && d_in_range && !d_is_mmio;
    assign tx_push = rstn && d_is_mmio && we[0];
    assign tx_pop  = tx_valid && tx_ready;

    // Data port: byte-lane write plus registered read; the read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < LANES; b++) begin
                if (we[b]) mem[d_ram_addr][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
        d_rd_raw <= mem[d_ram_addr];
    end

    // Instruction port: read-only registered read.
    always_ff @(posedge clk) begin
        i_rd_raw <= mem[i_ram_addr];
    end

    // First-stage select flags and TX status, captured with the request so the RAM outputs need no reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_mem_q  <= 1'b0;
            d_mmio_q <= 1'b0;
            d_stat_q <= 2'b00;
            i_mem_q  <= 1'b0;
        end else begin
            d_mem_q  <= d_in_range && !d_is_mmio;
            d_mmio_q <= d_is_mmio;
            d_stat_q <= {tx_empty, tx_full};
            i_mem_q  <= i_in_range && !i_is_mmio;
        end
    end

    assign d_stage1 = d_mmio_q ? {{(DATA_W-2){1'b0}}, d_stat_q} : (d_mem_q ? d_rd_raw : '0);
    assign i_stage1 = i_mem_q ? i_rd_raw : '0;

    if (LOAD_LATENCY == 1) begin : g_lat1
        assign ld_data          = d_stage1;
        assign ld_data_for_inst = i_stage1;
    end else begin : g_latn
        logic [DATA_W-1:0] d_pipe [LOAD_LATENCY-1];
        logic [DATA_W-1:0] i_pipe [LOAD_LATENCY-1];

        // Extra read latency stages for both ports.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int s = 0; s < LOAD_LATENCY-1; s++) begin
                    d_pipe[s] <= '0;
                    i_pipe[s] <= '0;
                end
            end else begin
                d_pipe[0] <= d_stage1;
                i_pipe[0] <= i_stage1;
                for (int s = 1; s < LOAD_LATENCY-1; s++) begin
                    d_pipe[s] <= d_pipe[s-1];
                    i_pipe[s] <= i_pipe[s-1];
                end
            end
        end

        assign ld_data          = d_pipe[LOAD_LATENCY-2];
        assign ld_data_for_inst = i_pipe[LOAD_LATENCY-2];
    end

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (TXQ_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (st_data[7:0]),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    assign tx_valid = !tx_empty;

    // Sticky overflow: a push was refused because the FIFO was full and nothing left it that cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_overflow <= 1'b0;
        end else if (tx_push && tx_full && !tx_pop) begin
            tx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_core_memory.sv
module tb_core_memory;

    localparam logic [15:0] IDLE = 16'h8000;
    localparam logic [15:0] MMIO = 16'hFFF8;
    localparam logic [63:0] W1   = 64'h1122334455667788;
    localparam logic [63:0] W2   = 64'hAA22334455667788;
    localparam logic [63:0] X1   = 64'h0123456789ABCDEF;
    localparam logic [63:0] X2   = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] Z0   = 64'h5A5A0000FFFF1234;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] pc_to_mem = IDLE;
    logic [15:0] mem_addr = IDLE;
    logic [63:0] st_data = '0;
    logic [7:0]  we = '0;
    logic        tx_ready = 1'b0;

    logic [63:0] ld1, ii1, ld3, ii3;
    logic [7:0]  txd1, txd3;
    logic        txv1, txv3, ovf1, ovf3;

    core_memory #(.LOAD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rstn(rstn), .pc_to_mem(pc_to_mem), .ld_data_for_inst(ii1),
        .mem_addr(mem_addr), .st_data(st_data), .we(we), .ld_data(ld1),
        .tx_data(txd1), .tx_valid(txv1), .tx_ready(tx_ready), .tx_overflow(ovf1)
    );

    core_memory #(.LOAD_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rstn(rstn), .pc_to_mem(pc_to_mem), .ld_data_for_inst(ii3),
        .mem_addr(mem_addr), .st_data(st_data), .we(we), .ld_data(ld3),
        .tx_data(txd3), .tx_valid(txv3), .tx_ready(tx_ready), .tx_overflow(ovf3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int          due;
        int          dut;
        int          port;
        logic [63:0] val;
        string       tag;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] txq1[$];
    logic [7:0] txq3[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] act_of(input int dut, input int port);
        if (dut == 1) return (port == 0) ? ld1 : ii1;
        return (port == 0) ? ld3 : ii3;
    endfunction

    // Expected read data for a request issued in the current cycle, for both latencies.
    task automatic exp_push(input int port, input logic [63:0] val, input string tag);
        sbq.push_back('{cyc + 1, 1, port, val, tag});
        sbq.push_back('{cyc + 3, 3, port, val, tag});
    endtask

    task automatic drive(input logic [15:0] pc, input logic [15:0] a, input logic [63:0] sd,
                         input logic [7:0] w, input bit cd, input logic [63:0] ed,
                         input bit ci, input logic [63:0] ei, input string tag);
        pc_to_mem = pc;
        mem_addr  = a;
        st_data   = sd;
        we        = w;
        if (cd) exp_push(0, ed, {tag, "_ld"});
        if (ci) exp_push(1, ei, {tag, "_inst"});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [15:0] pc, input logic [15:0] a, input logic [63:0] sd,
                       input logic [7:0] w, input bit cd, input logic [63:0] ed,
                       input bit ci, input logic [63:0] ei, input string tag);
        drive(pc, a, sd, w, cd, ed, ci, ei, tag);
        tick();
    endtask

    task automatic idle();
        req(IDLE, IDLE, '0, '0, 0, '0, 0, '0, "idle");
    endtask

    // Read-data monitor: compares every expectation that falls due this cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].due <= cyc) begin
                if (sbq[i].due < cyc) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL %s_l%0d: check missed at cycle %0d", sbq[i].tag, sbq[i].dut, cyc);
                end else begin
                    chk($sformatf("%s_l%0d", sbq[i].tag, sbq[i].dut),
                        act_of(sbq[i].dut, sbq[i].port), sbq[i].val);
                end
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    // TX stream monitor: each accepted byte must be the next expected one.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rstn && txv1 && tx_ready) begin
            if (txq1.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL tx_extra_l1: got %h expected no byte", txd1);
            end else begin
                e = txq1.pop_front();
                chk("tx_byte_l1", {56'b0, txd1}, {56'b0, e});
            end
        end
        if (rstn && txv3 && tx_ready) begin
            if (txq3.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL tx_extra_l3: got %h expected no byte", txd3);
            end else begin
                e = txq3.pop_front();
                chk("tx_byte_l3", {56'b0, txd3}, {56'b0, e});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ld1", ld1, '0);
        chk("rst_ld3", ld3, '0);
        chk("rst_ii1", ii1, '0);
        chk("rst_txv", {63'b0, txv1}, 64'd0);
        chk("rst_txd", {56'b0, txd1}, 64'd0);
        chk("rst_ovf", {63'b0, ovf1}, 64'd0);
        rstn = 1'b1;
        idle();
        idle();

        // Array read/write, lanes and read-during-write.
        req(IDLE, 16'h0040, W1, 8'hFF, 0, '0, 0, '0, "st_full");
        req(16'h0040, 16'h0040, '0, 8'h00, 1, W1, 1, W1, "load_full");
        req(IDLE, 16'h0040, 64'hAA00000000000000, 8'h80, 1, W1, 0, '0, "rdw_data_old");
        req(16'h0040, 16'h0040, '0, 8'h00, 1, W2, 1, W2, "partial_lane");
        req(16'h0040, 16'h0048, X1, 8'hFF, 0, '0, 1, W2, "fetch_vs_store");
        req(16'h0048, 16'h0048, X2, 8'hFF, 1, X1, 1, X1, "rdw_both_old");
        req(16'h0048, 16'h0048, '0, 8'h00, 1, X2, 1, X2, "new_word");
        req(IDLE, 16'h0000, Z0, 8'hFF, 0, '0, 0, '0, "st_zero");
        req(IDLE, 16'h8000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1, '0, 0, '0, "oob_read_zero");
        req(16'h8000, 16'h0000, '0, 8'h00, 1, Z0, 1, '0, "oob_no_wrap");
        req(IDLE, 16'h0048, 64'h0000000000000055, 8'h01, 1, X2, 0, '0, "lane0");
        req(IDLE, 16'h004F, 64'h0000330000440000, 8'h24, 1, 64'hDEADBEEFCAFEF055, 0, '0, "lanes_2_5");
        req(IDLE, 16'h0048, '0, 8'h00, 1, 64'hDEAD33EFCA44F055, 0, '0, "lanes_result");

        // MMIO status, fetch from MMIO, and a store that misses we[0].
        req(MMIO, MMIO, '0, 8'h00, 1, 64'd2, 1, '0, "mmio_empty");
        req(IDLE, MMIO, 64'h9900000000000000, 8'h80, 1, 64'd2, 0, '0, "mmio_we7");
        req(IDLE, MMIO, '0, 8'h00, 1, 64'd2, 0, '0, "mmio_no_push");
        chk("txv_no_push", {63'b0, txv1}, 64'd0);

        // Fill the FIFO; the first push must not show up in the same cycle.
        for (int i = 0; i < 16; i++) begin
            drive(IDLE, MMIO, 64'hFFFFFFFFFFFFFF00 | 64'(i), 8'h01, 1, (i == 0) ? 64'd2 : 64'd0, 0, '0, "fill_status");
            txq1.push_back(8'(i));
            txq3.push_back(8'(i));
            if (i == 0) begin
                #2;
                chk("no_fallthru", {63'b0, txv1}, 64'd0);
            end
            tick();
            if (i == 0) chk("push_visible", {63'b0, txv1}, 64'd1);
        end
        chk("ovf_before_full_push", {63'b0, ovf1}, 64'd0);

        // Push and pop while full: both happen, no overflow.
        tx_ready = 1'b1;
        req(IDLE, MMIO, 64'h0000000000000077, 8'h01, 1, 64'd1, 0, '0, "full_pushpop_status");
        txq1.push_back(8'h77);
        txq3.push_back(8'h77);
        tx_ready = 1'b0;
        chk("full_pushpop_no_ovf", {63'b0, ovf1}, 64'd0);

        // Push while full with no pop: dropped, overflow sticks.
        req(IDLE, MMIO, 64'h0000000000000010, 8'h01, 1, 64'd1, 0, '0, "overflow_status");
        chk("overflow_l1", {63'b0, ovf1}, 64'd1);
        chk("overflow_l3", {63'b0, ovf3}, 64'd1);
        req(IDLE, MMIO, '0, 8'h00, 1, 64'd1, 0, '0, "status_full");

        tx_ready = 1'b1;
        repeat (18) idle();
        chk("drain_txv", {63'b0, txv1}, 64'd0);
        chk("drain_left_l1", 64'(txq1.size()), 64'd0);
        chk("drain_left_l3", 64'(txq3.size()), 64'd0);
        chk("ovf_sticky", {63'b0, ovf1}, 64'd1);
        tx_ready = 1'b0;

        // Mid-drain reset with five bytes held and a load in flight.
        for (int i = 0; i < 7; i++) begin
            req(IDLE, MMIO, 64'h00000000000000A0 + 64'(i), 8'h01, 1, (i == 0) ? 64'd2 : 64'd0, 0, '0, "refill_status");
            txq1.push_back(8'hA0 + 8'(i));
            txq3.push_back(8'hA0 + 8'(i));
        end
        tx_ready = 1'b1;
        idle();
        idle();
        tx_ready = 1'b0;
        req(16'h0040, 16'h0040, '0, 8'h00, 0, '0, 0, '0, "inflight");
        #1;
        rstn = 1'b0;
        #1;
        chk("async_rst_txv1", {63'b0, txv1}, 64'd0);
        chk("async_rst_txv3", {63'b0, txv3}, 64'd0);
        chk("async_rst_txd", {56'b0, txd1}, 64'd0);
        chk("async_rst_ld1", ld1, '0);
        chk("async_rst_ld3", ld3, '0);
        chk("async_rst_ii1", ii1, '0);
        chk("async_rst_ovf", {63'b0, ovf1}, 64'd0);
        txq1.delete();
        txq3.delete();
        tick();
        req(IDLE, 16'h0040, 64'hBADBADBADBADBAD0, 8'hFF, 0, '0, 0, '0, "st_in_reset");
        rstn = 1'b1;
        req(16'h0040, 16'h0040, '0, 8'h00, 1, W2, 1, W2, "after_reset");
        chk("ld3_zero_after_release", ld3, '0);

        for (int k = 0; k < 20 && sbq.size() != 0; k++) idle();
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
